// File: rtl/eeprom_sequencer.sv
// Sequences Microwire-style EEPROM command lists (READ / WRITE / ERASE) onto an SPI engine,
// with per-wait timeouts and an idle window for the EEPROM internal program cycle.
module eeprom_sequencer #(
   parameter int WRITE_WAIT_CYCLES = 625000,
   parameter int TIMEOUT_CYCLES    = 8192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [1:0]  req_op,
   input  logic [5:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] rdata,
   output logic [7:0]  cmd,
   output logic [15:0] data_in,
   output logic        start,
   input  logic        cs,
   input  logic [15:0] data_out
);

   localparam logic [1:0] REQ_READ  = 2'b00;
   localparam logic [1:0] REQ_WRITE = 2'b01;
   localparam logic [1:0] REQ_ERASE = 2'b10;
   localparam logic [1:0] REQ_RSVD  = 2'b11;

   localparam int MAX_WAIT = (WRITE_WAIT_CYCLES > TIMEOUT_CYCLES) ? WRITE_WAIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW       = $clog2(MAX_WAIT + 1);

   localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CW-1:0] PW_LAST  = CW'((WRITE_WAIT_CYCLES > 0) ? WRITE_WAIT_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ISSUE      = 3'd1,
      WAIT_CS_HI = 3'd2,
      WAIT_CS_LO = 3'd3,
      PROG_WAIT  = 3'd4,
      DONE       = 3'd5
   } state_t;

   state_t        state_r;
   state_t        next_state_s;
   logic [1:0]    op_r;
   logic [5:0]    addr_r;
   logic [15:0]   wdata_r;
   logic [1:0]    idx_r;
   logic [CW-1:0] cnt_r;

   logic [1:0]    nxt_op_s;
   logic [5:0]    nxt_addr_s;
   logic [15:0]   nxt_wdata_s;
   logic [1:0]    nxt_idx_s;
   logic          fail_s;
   logic          load_rdata_s;
   logic          issue_s;

   // Entry idx of the command list for a request: EWEN, program command, EWDS.
   function automatic logic [7:0] entry_cmd(input logic [1:0] op, input logic [5:0] addr,
                                            input logic [1:0] idx);
      logic [7:0] c;
      c = 8'h00;
      case (op)
         REQ_READ: c = {2'b10, addr};
         REQ_WRITE, REQ_ERASE: begin
            case (idx)
               2'd0:    c = 8'b0011_0000;
               2'd1:    c = {((op == REQ_WRITE) ? 2'b01 : 2'b11), addr};
               default: c = 8'h00;
            endcase
         end
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Next-state and request/list bookkeeping.
   always_comb begin
      next_state_s = state_r;
      nxt_op_s     = op_r;
      nxt_addr_s   = addr_r;
      nxt_wdata_s  = wdata_r;
      nxt_idx_s    = idx_r;
      fail_s       = 1'b0;
      load_rdata_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req) begin
               next_state_s = ISSUE;
               nxt_op_s     = req_op;
               nxt_addr_s   = req_addr;
               nxt_wdata_s  = req_wdata;
               nxt_idx_s    = 2'd0;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            if (op_r == REQ_RSVD) begin
               next_state_s = DONE;
               fail_s       = 1'b1;
            end else begin
               next_state_s = WAIT_CS_HI;
            end
         end
         WAIT_CS_HI: begin
            if (cs) begin
               next_state_s = WAIT_CS_LO;
            end else if (cnt_r == TO_LAST) begin
               next_state_s = DONE;
               fail_s       = 1'b1;
            end else begin
               next_state_s = WAIT_CS_HI;
            end
         end
         WAIT_CS_LO: begin
            if (!cs) begin
               if (op_r == REQ_READ) begin
                  load_rdata_s = 1'b1;
                  next_state_s = DONE;
               end else if (idx_r == 2'd2) begin
                  next_state_s = DONE;
               end else if (idx_r == 2'd1) begin
                  next_state_s = PROG_WAIT;
               end else begin
                  next_state_s = ISSUE;
                  nxt_idx_s    = idx_r + 2'd1;
               end
            end else if (cnt_r == TO_LAST) begin
               next_state_s = DONE;
               fail_s       = 1'b1;
            end else begin
               next_state_s = WAIT_CS_LO;
            end
         end
         PROG_WAIT: begin
            if (cnt_r == PW_LAST) begin
               next_state_s = ISSUE;
               nxt_idx_s    = 2'd2;
            end else begin
               next_state_s = PROG_WAIT;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // A reserved op passes through ISSUE without touching the SPI engine.
   assign issue_s = (next_state_s == ISSUE) && (nxt_op_s != REQ_RSVD);

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         op_r    <= 2'b00;
         addr_r  <= 6'd0;
         wdata_r <= 16'h0000;
         idx_r   <= 2'd0;
         cnt_r   <= CNT_ZERO;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         rdata   <= 16'h0000;
         cmd     <= 8'h00;
         data_in <= 16'h0000;
         start   <= 1'b0;
      end else begin
         state_r <= next_state_s;
         op_r    <= nxt_op_s;
         addr_r  <= nxt_addr_s;
         wdata_r <= nxt_wdata_s;
         idx_r   <= nxt_idx_s;
         if (next_state_s != state_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
         busy  <= (next_state_s == ISSUE) || (next_state_s == WAIT_CS_HI) ||
                  (next_state_s == WAIT_CS_LO) || (next_state_s == PROG_WAIT);
         done  <= (next_state_s == DONE);
         error <= fail_s;
         start <= issue_s;
         if (load_rdata_s) begin
            rdata <= data_out;
         end
         // cmd/data_in only change on a new issue, so they hold through the whole SPI transfer.
         if (issue_s) begin
            cmd     <= entry_cmd(nxt_op_s, nxt_addr_s, nxt_idx_s);
            data_in <= ((nxt_op_s == REQ_WRITE) && (nxt_idx_s == 2'd1)) ? nxt_wdata_s : 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_eeprom_sequencer.sv
// Directed bench for eeprom_sequencer: a vector table of whole transactions plus
// hand-written timeout, reset and held-request sequences against a small SPI engine model.
module tb_eeprom_sequencer;

   localparam int WW = 100;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [1:0]  req_op;
   logic [5:0]  req_addr;
   logic [15:0] req_wdata;
   logic        busy, done, error, start, cs;
   logic [15:0] rdata, data_in, data_out;
   logic [7:0]  cmd;

   eeprom_sequencer #(.WRITE_WAIT_CYCLES(WW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(busy), .done(done), .error(error), .rdata(rdata),
      .cmd(cmd), .data_in(data_in), .start(start), .cs(cs), .data_out(data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // start monitor: logs cmd/data_in/cycle of every pulse and flags adjacent pulses
   int          n_start = 0;
   int          adj_cnt = 0;
   logic        prev_start = 1'b0;
   logic [7:0]  cmd_log   [0:63];
   logic [15:0] din_log   [0:63];
   int          start_log [0:63];
   initial begin
      forever begin
         @(negedge clk);
         if (start) begin
            if (n_start < 64) begin
               cmd_log[n_start]   = cmd;
               din_log[n_start]   = data_in;
               start_log[n_start] = cyc;
            end
            n_start = n_start + 1;
            if (prev_start) adj_cnt = adj_cnt + 1;
         end
         prev_start = start;
      end
   end

   // SPI engine model. mode 0: normal, 1: never raises cs, 2: holds cs high until mode leaves 2
   int          spi_mode = 0;
   logic [15:0] spi_val  = 16'h0000;
   int          n_fall   = 0;
   int          fall_log [0:63];
   initial begin
      cs       = 1'b0;
      data_out = 16'h0000;
      forever begin
         @(negedge clk);
         if (start && spi_mode != 1) begin
            repeat (2) @(posedge clk);
            #1 cs = 1'b1;
            if (spi_mode == 2) begin
               while (spi_mode == 2) @(posedge clk);
               #1;
            end else begin
               repeat (3) @(posedge clk);
               #1;
            end
            data_out = spi_val;
            cs       = 1'b0;
            if (n_fall < 64) fall_log[n_fall] = cyc;
            n_fall = n_fall + 1;
         end
      end
   end

   logic        got_done, got_err, got_busy;
   logic [15:0] got_rdata;
   int          done_cyc, lat;

   task automatic do_txn(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] wd,
                         input int budget);
      int waited;
      req       = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(negedge clk);
      req = 1'b0;
      waited = 0;
      while (!done && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      got_done  = done;
      got_err   = error;
      got_rdata = rdata;
      got_busy  = busy;
      done_cyc  = cyc;
      lat       = waited + 1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  addr;
      logic [15:0] wdata;
      logic [15:0] spi;
      int          nstart;
      logic [7:0]  c0, c1, c2;
      logic        err;
      logic [15:0] rd;
   } vec_t;

   vec_t tv [0:6];

   initial begin
      int base, fbase, w;
      logic idle_bad;

      rst = 1'b1; req = 1'b0; req_op = 2'b00; req_addr = 6'd0; req_wdata = 16'h0000;

      tv[0] = '{2'b00, 6'h05, 16'h0000, 16'hBEEF, 1, 8'h85, 8'h00, 8'h00, 1'b0, 16'hBEEF};
      tv[1] = '{2'b01, 6'h3F, 16'h1234, 16'h0000, 3, 8'h30, 8'h7F, 8'h00, 1'b0, 16'hBEEF};
      tv[2] = '{2'b00, 6'h00, 16'h0000, 16'h0000, 1, 8'h80, 8'h00, 8'h00, 1'b0, 16'h0000};
      tv[3] = '{2'b10, 6'h0A, 16'h0000, 16'hFFFF, 3, 8'h30, 8'hCA, 8'h00, 1'b0, 16'h0000};
      tv[4] = '{2'b01, 6'h01, 16'hFFFF, 16'h0000, 3, 8'h30, 8'h41, 8'h00, 1'b0, 16'h0000};
      tv[5] = '{2'b00, 6'h2A, 16'h0000, 16'h5A5A, 1, 8'hAA, 8'h00, 8'h00, 1'b0, 16'h5A5A};
      tv[6] = '{2'b11, 6'h15, 16'hAAAA, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 1'b1, 16'h5A5A};

      repeat (3) @(negedge clk);
      check("reset_busy",    32'(busy),    32'd0);
      check("reset_done",    32'(done),    32'd0);
      check("reset_error",   32'(error),   32'd0);
      check("reset_start",   32'(start),   32'd0);
      check("reset_rdata",   32'(rdata),   32'd0);
      check("reset_cmd",     32'(cmd),     32'd0);
      check("reset_data_in", 32'(data_in), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         spi_val = tv[i].spi;
         base    = n_start;
         fbase   = n_fall;
         do_txn(tv[i].op, tv[i].addr, tv[i].wdata, 500);
         check($sformatf("v%0d_done", i),  32'(got_done),  32'd1);
         check($sformatf("v%0d_error", i), 32'(got_err),   32'(tv[i].err));
         check($sformatf("v%0d_rdata", i), 32'(got_rdata), 32'(tv[i].rd));
         check($sformatf("v%0d_busy_at_done", i), 32'(got_busy), 32'd0);
         check($sformatf("v%0d_nstart", i), 32'(n_start - base), 32'(tv[i].nstart));
         if (tv[i].nstart > 0)
            check($sformatf("v%0d_cmd0", i), 32'(cmd_log[base]), 32'(tv[i].c0));
         if (tv[i].nstart > 2) begin
            check($sformatf("v%0d_cmd1", i), 32'(cmd_log[base+1]), 32'(tv[i].c1));
            check($sformatf("v%0d_cmd2", i), 32'(cmd_log[base+2]), 32'(tv[i].c2));
            check_range($sformatf("v%0d_prog_wait", i),
                        start_log[base+2] - fall_log[fbase+1], WW, WW + 2);
         end
         if (tv[i].op == 2'b01)
            check($sformatf("v%0d_data_in", i), 32'(din_log[base+1]), 32'(tv[i].wdata));
         if (tv[i].op == 2'b11)
            check("rsvd_latency", 32'(lat), 32'd2);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         @(negedge clk);
      end

      // cs never rises: timeout TO cycles after entering WAIT_CS_HI, EWDS abandoned
      spi_mode = 1;
      base     = n_start;
      do_txn(2'b01, 6'h12, 16'h4321, 200);
      check("to_hi_done",    32'(got_done), 32'd1);
      check("to_hi_error",   32'(got_err),  32'd1);
      check("to_hi_latency", 32'(done_cyc - start_log[base]), 32'(TO + 1));
      check("to_hi_rdata",   32'(got_rdata), 32'h5A5A);
      repeat (20) @(negedge clk);
      check("to_hi_nstart",  32'(n_start - base), 32'd1);
      spi_mode = 0;

      // cs stuck high: timeout in WAIT_CS_LO, rdata must not load
      spi_mode = 2;
      spi_val  = 16'hDEAD;
      base     = n_start;
      do_txn(2'b00, 6'h03, 16'h0000, 200);
      check("to_lo_done",    32'(got_done),  32'd1);
      check("to_lo_error",   32'(got_err),   32'd1);
      check("to_lo_rdata",   32'(got_rdata), 32'h5A5A);
      check("to_lo_latency", 32'(done_cyc - start_log[base]), 32'(TO + 3));
      spi_mode = 0;
      w = 0;
      while (cs && w < 20) begin @(negedge clk); w++; end
      check("to_lo_cs_released", 32'(cs), 32'd0);
      repeat (3) @(negedge clk);

      // reset during WAIT_CS_LO of the WRITE program entry
      spi_val = 16'h0000;
      base    = n_start;
      req = 1'b1; req_op = 2'b01; req_addr = 6'h20; req_wdata = 16'hCAFE;
      @(negedge clk);
      req = 1'b0;
      w = 0;
      while ((n_start - base) < 2 && w < 300) begin @(negedge clk); w++; end
      check("rst_reached_entry2", 32'(n_start - base), 32'd2);
      w = 0;
      while (!cs && w < 20) begin @(negedge clk); w++; end
      check("rst_cs_high", 32'(cs), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_error",   32'(error),   32'd0);
      check("rst_start",   32'(start),   32'd0);
      check("rst_rdata",   32'(rdata),   32'd0);
      check("rst_cmd",     32'(cmd),     32'd0);
      check("rst_data_in", 32'(data_in), 32'd0);
      rst = 1'b0;
      idle_bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (busy || start || done) idle_bad = 1'b1;
      end
      check("rst_ignores_inflight", 32'(idle_bad), 32'd0);
      spi_val = 16'h1357;
      base    = n_start;
      do_txn(2'b00, 6'h11, 16'h0000, 200);
      check("post_rst_done",   32'(got_done),  32'd1);
      check("post_rst_error",  32'(got_err),   32'd0);
      check("post_rst_rdata",  32'(got_rdata), 32'h1357);
      check("post_rst_cmd",    32'(cmd_log[base]), 32'h91);
      check("post_rst_nstart", 32'(n_start - base), 32'd1);
      repeat (2) @(negedge clk);

      // req held high through a READ: next acceptance only after done
      spi_val = 16'h2468;
      base    = n_start;
      req = 1'b1; req_op = 2'b00; req_addr = 6'h07; req_wdata = 16'h0000;
      w = 0;
      @(negedge clk);
      while (!done && w < 200) begin @(negedge clk); w++; end
      check("held_done1", 32'(done), 32'd1);
      done_cyc = cyc;
      check("held_nstart_at_done", 32'(n_start - base), 32'd1);
      w = 0;
      while ((n_start - base) < 2 && w < 20) begin @(negedge clk); w++; end
      req = 1'b0;
      check("held_second_start", 32'(n_start - base), 32'd2);
      check("held_accept_gap", 32'(start_log[base+1] - done_cyc), 32'd2);
      w = 0;
      while (!done && w < 200) begin @(negedge clk); w++; end
      check("held_done2",  32'(done),  32'd1);
      check("held_rdata2", 32'(rdata), 32'h2468);
      repeat (3) @(negedge clk);

      check("no_adjacent_start", 32'(adj_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
